// File: rtl/contador_rega.sv
// Irrigation countdown timer: drives the BCD digit and error flag for the display decoder,
// opens the valve for PRESET time units of TPU ticks each and flags invalid presets or faults.
module contador_rega #(
   parameter int unsigned TPU = 60
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       TICK,
   input  logic       START,
   input  logic       STOP,
   input  logic       FAULT,
   input  logic [3:0] PRESET,
   output logic       C3,
   output logic       C2,
   output logic       C1,
   output logic       C0,
   output logic       Er,
   output logic       VALVE,
   output logic       DONE
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      ERROR = 2'd2
   } state_t;

   localparam logic [7:0] LAST_TICK = 8'(TPU - 1);

   state_t     state;
   logic [3:0] digit;
   logic [7:0] prescaler;
   logic       startQ;
   logic       erReg;
   logic       valveReg;
   logic       doneReg;
   logic       startEdge;

   function automatic logic presetValid(input logic [3:0] p);
      return (p >= 4'd1) && (p <= 4'd9);
   endfunction

   assign startEdge = START & ~startQ;

   // Main controller: state, digit, prescaler and all registered outputs.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= IDLE;
         digit     <= 4'd0;
         prescaler <= 8'd0;
         startQ    <= 1'b1;
         erReg     <= 1'b0;
         valveReg  <= 1'b0;
         doneReg   <= 1'b0;
      end else begin
         startQ  <= START;
         doneReg <= 1'b0;
         case (state)
            IDLE: begin
               if (FAULT) begin
                  state    <= ERROR;
                  erReg    <= 1'b1;
                  digit    <= 4'd0;
                  valveReg <= 1'b0;
               end else if (startEdge) begin
                  if (presetValid(PRESET)) begin
                     state     <= RUN;
                     digit     <= PRESET;
                     prescaler <= 8'd0;
                     valveReg  <= 1'b1;
                  end else begin
                     state    <= ERROR;
                     erReg    <= 1'b1;
                     digit    <= 4'd0;
                     valveReg <= 1'b0;
                  end
               end else begin
                  digit    <= 4'd0;
                  valveReg <= 1'b0;
               end
            end
            RUN: begin
               if (FAULT) begin
                  state    <= ERROR;
                  erReg    <= 1'b1;
                  digit    <= 4'd0;
                  valveReg <= 1'b0;
               end else if (STOP) begin
                  state    <= IDLE;
                  digit    <= 4'd0;
                  valveReg <= 1'b0;
               end else if (TICK) begin
                  if (prescaler >= LAST_TICK) begin
                     prescaler <= 8'd0;
                     // Digit never sits at 0 in RUN; <= 1 also guards a corrupted digit
                     if (digit <= 4'd1) begin
                        state    <= IDLE;
                        digit    <= 4'd0;
                        valveReg <= 1'b0;
                        doneReg  <= 1'b1;
                     end else begin
                        digit <= digit - 4'd1;
                     end
                  end else begin
                     prescaler <= prescaler + 8'd1;
                  end
               end else begin
                  prescaler <= prescaler;
               end
            end
            ERROR: begin
               digit    <= 4'd0;
               valveReg <= 1'b0;
               if (STOP && !FAULT) begin
                  state <= IDLE;
                  erReg <= 1'b0;
               end else begin
                  erReg <= 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               digit    <= 4'd0;
               erReg    <= 1'b0;
               valveReg <= 1'b0;
            end
         endcase
      end
   end

   assign {C3, C2, C1, C0} = digit;
   assign Er               = erReg;
   assign VALVE            = valveReg;
   assign DONE             = doneReg;

   contador_rega_chk #(.TPU(TPU)) chk (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .inRun    (state == RUN),
      .inError  (state == ERROR),
      .digit    (digit),
      .prescaler(prescaler),
      .erFlag   (erReg),
      .valveOn  (valveReg)
   );

endmodule

// Invariant checker for contador_rega: digit range, prescaler range and output/state coherence.
module contador_rega_chk #(
   parameter int unsigned TPU = 60
) (
   input logic       CLK,
   input logic       RST_N,
   input logic       inRun,
   input logic       inError,
   input logic [3:0] digit,
   input logic [7:0] prescaler,
   input logic       erFlag,
   input logic       valveOn
);

   localparam logic [8:0] TPU_W = 9'(TPU);

   digitRange: assert property (@(posedge CLK) disable iff (!RST_N) digit <= 4'd9);
   prescRange: assert property (@(posedge CLK) disable iff (!RST_N) {1'b0, prescaler} < TPU_W);
   erMatches:  assert property (@(posedge CLK) disable iff (!RST_N) erFlag == inError);
   valveMatch: assert property (@(posedge CLK) disable iff (!RST_N) valveOn == inRun);

endmodule

// File: doc/contador_rega.md
# contador_rega

Irrigation countdown timer that drives the seven-segment display decoder: it produces the BCD digit (C3..C0) and the error flag (Er) that the decoder turns into segment lines. It opens the valve for a preset number of time units, counts the digit down from the preset to 0, and forces Er when the preset is invalid or a fault occurs. Er=1 blanks the display through the decoder.

## Interface
- TPU, default 60: TICK strobes per time unit; legal range 1..255.
- CLK  in  1  system clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- TICK  in  1  one-cycle time-base strobe (e.g. 1 Hz) from the prescaler.
- START  in  1  start button level, synchronous to CLK; acts on its rising edge.
- STOP  in  1  level; aborts a run or clears an error.
- FAULT  in  1  level; sensor or low-water fault.
- PRESET  in  4  run duration in units; legal 1..9.
- C3, C2, C1, C0  out  1 each  current BCD digit, MSB..LSB, to the display decoder.
- Er  out  1  error flag to the display decoder.
- VALVE  out  1  valve drive; 1 = open.
- DONE  out  1  one-cycle pulse when a run completes normally.

## Operation
- States: IDLE, RUN, ERROR. All outputs are registered.
- Start edge: start_edge = START & ~start_q, where start_q is START delayed by one cycle. start_q resets to 1, so a button held through reset does not start a run.
- Priority each cycle: FAULT, then STOP, then START edge / TICK.
- IDLE:
  - FAULT=1 -> ERROR.
  - start_edge with PRESET in 1..9 -> RUN; C=PRESET, prescaler=0, VALVE=1.
  - start_edge with PRESET=0 or >9 -> ERROR.
  - Otherwise C=0 and VALVE=0.
- RUN:
  - FAULT=1 -> ERROR, VALVE=0.
  - Otherwise STOP=1 -> IDLE, C=0, VALVE=0, no DONE.
  - Otherwise on TICK: if prescaler==TPU-1, prescaler=0 and C=C-1; else prescaler+1.
  - When the decrement takes C from 1 to 0: -> IDLE, VALVE=0, DONE=1 for that one cycle.
  - START edges are ignored (no retrigger). PRESET changes have no effect once running.
- ERROR:
  - Er=1, C=0, VALVE=0.
  - Exit to IDLE only on a cycle with STOP=1 and FAULT=0; Er=0 from that cycle on.
  - START is ignored.
- Er=1 only in ERROR. C never exceeds 9. The prescaler is 8 bits and never reaches TPU.

## Timing
- Reset (RST_N=0, immediate): state=IDLE, C3..C0=0000, Er=0, VALVE=0, DONE=0, prescaler=0, start_q=1.
- Reset asserted mid-run: the valve closes asynchronously and all the reset values above apply.
- START rising at edge k (START=1 sampled at k, 0 at k-1): at edge k, C=PRESET and VALVE=1.
- Each unit takes TPU TICK strobes. A run of PRESET=N lasts N*TPU TICKs.
- Last TICK at edge m: C=0, VALVE=0, DONE=1 after edge m; DONE=0 after edge m+1.
- FAULT sampled at edge k: Er=1 and VALVE=0 after edge k, even if TICK, STOP or START is active in the same cycle.
- STOP together with the final decrementing TICK: STOP wins -> IDLE with no DONE.
- start_edge on the cycle ERROR exits to IDLE: ignored, because the state is evaluated as ERROR on that cycle.

## Test plan
- Reset: hold RST_N=0 with START=1, then release -> C=0000, Er=0, VALVE=0, and no run starts until START goes 0 then 1.
- Normal run (TPU=2, PRESET=3): START edge, then 6 TICKs -> C sequence 3,3,2,2,1,1,0; VALVE=1 from the start edge until the 6th TICK; one DONE pulse; back in IDLE.
- Invalid preset: PRESET=0 and separately PRESET=12 with a START edge -> Er=1, VALVE=0, C=0000. Er stays 1 until STOP=1 with FAULT=0, then clears.
- Fault mid-run: TPU=2, PRESET=5, FAULT=1 after 3 TICKs -> Er=1 and VALVE=0 on the next edge. STOP while FAULT=1 is ignored; after FAULT=0, STOP returns to IDLE.
- Abort and ignore: STOP during RUN at C=4 -> C=0, VALVE=0, DONE stays 0. A START edge during RUN does not reload C.
- Simultaneous events: FAULT, STOP and the final TICK in one cycle -> ERROR, no DONE. STOP with the final TICK -> IDLE, no DONE.
